// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns,
// scan FSM state type, counter width and small one-hot helpers.
package seg_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

    // Patterns are ordered {a,b,c,d,e,f,g} with segment a in the MSB.
    localparam logic [6:0] PAT_0 = 7'b1111110;
    localparam logic [6:0] PAT_1 = 7'b0110000;
    localparam logic [6:0] PAT_2 = 7'b1101101;
    localparam logic [6:0] PAT_3 = 7'b1111001;
    localparam logic [6:0] PAT_4 = 7'b0110011;
    localparam logic [6:0] PAT_5 = 7'b1011011;
    localparam logic [6:0] PAT_6 = 7'b1011111;
    localparam logic [6:0] PAT_7 = 7'b1110000;
    localparam logic [6:0] PAT_8 = 7'b1111111;
    localparam logic [6:0] PAT_9 = 7'b1111011;
    localparam logic [6:0] PAT_A = 7'b1110111;
    localparam logic [6:0] PAT_B = 7'b0011111;
    localparam logic [6:0] PAT_C = 7'b1001110;
    localparam logic [6:0] PAT_D = 7'b0111101;
    localparam logic [6:0] PAT_E = 7'b1001111;
    localparam logic [6:0] PAT_F = 7'b1000111;

    function automatic logic is_one_hot(input logic [3:0] v);
        logic res;
        res = (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
        return res;
    endfunction

    function automatic logic [1:0] one_hot_index(input logic [3:0] v);
        logic [1:0] res;
        case (v)
            4'b0010: res = 2'd1;
            4'b0100: res = 2'd2;
            4'b1000: res = 2'd3;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; valid is low for
// any pattern outside the 16-entry table.
module seg_pattern_decode (
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       valid
);
    import seg_pkg::*;

    // Table lookup; unknown patterns report nibble 0 with valid low.
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (pattern)
            PAT_0:   nibble = 4'h0;
            PAT_1:   nibble = 4'h1;
            PAT_2:   nibble = 4'h2;
            PAT_3:   nibble = 4'h3;
            PAT_4:   nibble = 4'h4;
            PAT_5:   nibble = 4'h5;
            PAT_6:   nibble = 4'h6;
            PAT_7:   nibble = 4'h7;
            PAT_8:   nibble = 4'h8;
            PAT_9:   nibble = 4'h9;
            PAT_A:   nibble = 4'hA;
            PAT_B:   nibble = 4'hB;
            PAT_C:   nibble = 4'hC;
            PAT_D:   nibble = 4'hD;
            PAT_E:   nibble = 4'hE;
            PAT_F:   nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit seven-segment bus and reassembles debounced
// 16-bit frames. Optional macro SEG_SCAN_DECODER_DP_EN adds decimal-point capture.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic [3:0]  an,
`ifdef SEG_SCAN_DECODER_DP_EN
    input  logic        dp,
    output logic [3:0]  out_dp,
`endif
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  err,
    output logic        drop
);
    import seg_pkg::*;

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [6:0]       SEG_INV    = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]       AN_INV     = {4{SEG_ACTIVE_LOW}};
`ifdef SEG_SCAN_DECODER_DP_EN
    localparam int SAMPLE_W = 12;
`else
    localparam int SAMPLE_W = 11;
`endif

    // Sample layout: {[dp,] an[3:0], a..g}; dp only exists in the DP build.
    logic [SAMPLE_W-1:0] sample_in_s;
    logic [SAMPLE_W-1:0] sample_r;
    logic [SAMPLE_W-1:0] prev_r;
    logic [3:0]          an_s;
    logic [6:0]          seg_s;

`ifdef SEG_SCAN_DECODER_DP_EN
    assign sample_in_s = {dp ^ SEG_ACTIVE_LOW, an ^ AN_INV, {a, b, c, d, e, f, g} ^ SEG_INV};
`else
    assign sample_in_s = {an ^ AN_INV, {a, b, c, d, e, f, g} ^ SEG_INV};
`endif
    assign an_s  = sample_r[10:7];
    assign seg_s = sample_r[6:0];

    scan_state_t      state_r;
    scan_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             counting_s;
    logic             capture_s;
    logic             one_hot_s;
    logic             same_s;
    logic [1:0]       idx_s;
    logic [3:0]       dec_nibble_s;
    logic             dec_valid_s;

    logic [15:0]      frame_r;
    logic [15:0]      frame_nxt_s;
    logic [3:0]       mask_r;
    logic [3:0]       mask_nxt_s;
    logic [3:0]       err_nxt_s;
    logic             frame_full_s;

    assign one_hot_s = is_one_hot(an_s);
    assign same_s    = (sample_r == prev_r);
    assign idx_s     = one_hot_index(an_s);

    seg_pattern_decode u_decode (
        .pattern (seg_s),
        .nibble  (dec_nibble_s),
        .valid   (dec_valid_s)
    );

    // Scan FSM next-state: counting_s marks cycles where the counter was
    // loaded or advanced, so capture fires exactly once per stable run.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        counting_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (one_hot_s) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_ONE;
                    counting_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_SETTLE: begin
                if (!one_hot_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (same_s) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    counting_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = CNT_ONE;
                    counting_s  = 1'b1;
                end
            end
            ST_HELD: begin
                if (!one_hot_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!same_s) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_ONE;
                    counting_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign capture_s = counting_s && (cnt_nxt_s == STABLE_CNT);

    // Frame buffer update on capture; invalid patterns only raise err.
    always_comb begin
        frame_nxt_s = frame_r;
        mask_nxt_s  = mask_r;
        err_nxt_s   = err;
        if (capture_s && dec_valid_s) begin
            frame_nxt_s[{idx_s, 2'b00} +: 4] = dec_nibble_s;
            mask_nxt_s[idx_s]                = 1'b1;
        end else if (capture_s) begin
            err_nxt_s[idx_s] = 1'b1;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    assign frame_full_s = (mask_nxt_s == 4'b1111);

    // Input register and scan FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_r <= {SAMPLE_W{1'b0}};
            prev_r   <= {SAMPLE_W{1'b0}};
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
        end else begin
            sample_r <= sample_in_s;
            prev_r   <= sample_r;
            state_r  <= capture_s ? ST_HELD : state_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Frame assembly and hand-off; a full frame is dropped only when the
    // previous one is still pending and not being accepted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_r   <= 16'h0000;
            mask_r    <= 4'b0000;
            out       <= 16'h0000;
            out_valid <= 1'b0;
            err       <= 4'b0000;
            drop      <= 1'b0;
        end else begin
            frame_r <= frame_nxt_s;
            err     <= err_nxt_s;
            if (frame_full_s) begin
                mask_r <= 4'b0000;
                if (!out_valid || out_ready) begin
                    out       <= frame_nxt_s;
                    out_valid <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else begin
                mask_r <= mask_nxt_s;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= out_valid;
                end
            end
        end
    end

`ifdef SEG_SCAN_DECODER_DP_EN
    logic [3:0] dp_frame_r;

    // Decimal points ride along with the nibbles and leave with the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_frame_r <= 4'b0000;
            out_dp     <= 4'b0000;
        end else begin
            if (capture_s && dec_valid_s) begin
                dp_frame_r[idx_s] <= sample_r[11];
            end else begin
                dp_frame_r <= dp_frame_r;
            end
            if (frame_full_s && (!out_valid || out_ready)) begin
                out_dp <= dp_frame_r;
                out_dp[idx_s] <= (capture_s && dec_valid_s) ? sample_r[11] : dp_frame_r[idx_s];
            end else begin
                out_dp <= out_dp;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random
// scan traffic checked against a sample-history reference model.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
    localparam logic [6:0] PAT_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg = 7'b0000000;
    logic        a, b, c, d, e, f, g;
    logic [3:0]  an = 4'b0000;
    logic        dp = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic [3:0]  err;
    logic        drop;
`ifdef SEG_SCAN_DECODER_DP_EN
    logic [3:0]  out_dp;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    assign {a, b, c, d, e, f, g} = seg;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .an(an),
`ifdef SEG_SCAN_DECODER_DP_EN
        .dp(dp), .out_dp(out_dp),
`endif
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .drop(drop)
    );

    // Reference model: history of registered samples {dp, an, seg}.
    logic [11:0] hist[$];
    logic [11:0] m_reg = 12'h000;
    logic [15:0] m_out = 16'h0000;
    logic [15:0] m_frame = 16'h0000;
    logic        m_ov = 1'b0;
    logic        m_drop = 1'b0;
    logic [3:0]  m_err = 4'b0000;
    logic [3:0]  m_mask = 4'b0000;

    // A digit is captured when the newest sample is one-hot and the run of
    // identical trailing samples is exactly STABLE long.
    function automatic bit run_just_reached();
        int n;
        logic [11:0] cur;
        n = hist.size();
        if (n < STABLE) return 1'b0;
        cur = hist[n-1];
        if ($countones(cur[10:7]) != 1) return 1'b0;
        for (int j = 2; j <= STABLE; j++)
            if (hist[n-j] != cur) return 1'b0;
        if (n > STABLE && hist[n-STABLE-1] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle();
        logic [3:0]  nm;
        logic [15:0] nf;
        int idx;
        int nib;
        @(posedge clk);
        if (reset) begin
            m_reg = 12'h000; hist.delete();
            m_out = 16'h0000; m_frame = 16'h0000; m_ov = 1'b0;
            m_drop = 1'b0; m_err = 4'b0000; m_mask = 4'b0000;
        end else begin
            hist.push_back(m_reg);
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
            nm = m_mask;
            nf = m_frame;
            if (run_just_reached()) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (m_reg[7+k]) idx = k;
                nib = -1;
                for (int k = 0; k < 16; k++) if (PAT_TAB[k] == m_reg[6:0]) nib = k;
                if (nib >= 0) begin
                    nf[idx*4 +: 4] = 4'(nib);
                    nm[idx] = 1'b1;
                end else begin
                    m_err[idx] = 1'b1;
                end
            end
            if (nm == 4'hF) begin
                nm = 4'h0;
                if (!m_ov || out_ready) begin
                    m_out = nf;
                    m_ov = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            m_mask = nm;
            m_frame = nf;
            m_reg = {dp, an, seg};
        end
        #1;
    endtask

    task automatic show(input logic [3:0] an_v, input logic [6:0] pat, input int n);
        an = an_v;
        seg = pat;
        repeat (n) cycle();
    endtask

    task automatic show_frame(input logic [15:0] val);
        for (int dg = 3; dg >= 0; dg--)
            show(4'b0001 << dg, PAT_TAB[val[dg*4 +: 4]], STABLE);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        an = 4'($urandom_range(0, 15));
        seg = 7'($urandom);
        cycle();
        cycle();
        reset = 1'b0;
        tests_run++; if (out !== 16'h0000) begin tests_failed++; $display("FAIL reset_out: got %h want 0000", out); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests_run++; if (err !== 4'b0000) begin tests_failed++; $display("FAIL reset_err: got %b want 0000", err); end
        tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("FAIL reset_drop: got %b want 0", drop); end
    endtask

    task automatic test_frame();
        out_ready = 1'b0;
        show(4'b0001, 7'b1111001, 4);
        show(4'b0010, 7'b0110000, 4);
        show(4'b0100, 7'b1101101, 4);
        show(4'b1000, 7'b1111110, 4);
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out !== 16'h0213) begin tests_failed++; $display("FAIL frame_out: got %h want 0213", out); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid: got %b want 1", out_valid); end
        tests_run++; if (err !== 4'b0000) begin tests_failed++; $display("FAIL frame_err: got %b want 0000", err); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_consume: got %b want 0", out_valid); end
    endtask

    task automatic test_settle();
        do_reset();
        show(4'b0010, PAT_TAB[1], 4);
        show(4'b0100, PAT_TAB[2], 4);
        show(4'b1000, PAT_TAB[3], 4);
        show(4'b0001, PAT_TAB[5], 2);
        seg = PAT_TAB[7];
        for (int k = 1; k <= 5; k++) begin
            cycle();
            tests_run++;
            if (out_valid !== (k == 5)) begin
                tests_failed++;
                $display("FAIL settle_timing: cycle %0d got %b want %b", k, out_valid, (k == 5));
            end
        end
        tests_run++; if (out !== 16'h3217) begin tests_failed++; $display("FAIL settle_out: got %h want 3217", out); end
    endtask

    task automatic test_invalid();
        do_reset();
        show(4'b0001, PAT_TAB[0], 4);
        show(4'b0010, PAT_TAB[1], 4);
        show(4'b1000, PAT_TAB[3], 4);
        show(4'b0100, 7'b0000001, 6);
        tests_run++; if (err !== 4'b0100) begin tests_failed++; $display("FAIL invalid_err: got %b want 0100", err); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL invalid_noframe: got %b want 0", out_valid); end
        show(4'b0100, PAT_TAB[9], 5);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL invalid_recover: got %b want 1", out_valid); end
        tests_run++; if (out !== 16'h3910) begin tests_failed++; $display("FAIL invalid_out: got %h want 3910", out); end
        tests_run++; if (err !== 4'b0100) begin tests_failed++; $display("FAIL invalid_sticky: got %b want 0100", err); end
    endtask

    task automatic test_drop();
        do_reset();
        out_ready = 1'b0;
        show_frame(16'h1234);
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out !== 16'h1234) begin tests_failed++; $display("FAIL drop_first: got %h want 1234", out); end
        tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("FAIL drop_early: got %b want 0", drop); end
        show_frame(16'h5678);
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out !== 16'h1234) begin tests_failed++; $display("FAIL drop_hold: got %h want 1234", out); end
        tests_run++; if (drop !== 1'b1) begin tests_failed++; $display("FAIL drop_flag: got %b want 1", drop); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL drop_valid: got %b want 1", out_valid); end
        do_reset();
        show_frame(16'h1234);
        show_frame(16'h5678);
        out_ready = 1'b1;
        show(4'b0000, 7'b0000000, 1);
        out_ready = 1'b0;
        tests_run++; if (out !== 16'h5678) begin tests_failed++; $display("FAIL accept_out: got %h want 5678", out); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL accept_valid: got %b want 1", out_valid); end
        tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("FAIL accept_drop: got %b want 0", drop); end
    endtask

    task automatic test_not_one_hot();
        do_reset();
        show(4'b0011, PAT_TAB[8], 10);
        tests_run++; if (err !== 4'b0000) begin tests_failed++; $display("FAIL multi_an_err: got %b want 0000", err); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL multi_an_valid: got %b want 0", out_valid); end
        show(4'b0001, PAT_TAB[1], 4);
        show(4'b0010, PAT_TAB[2], 4);
        show(4'b0100, PAT_TAB[3], 4);
        do_reset();
        show(4'b1000, PAT_TAB[4], 4);
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL partial_reset: got %b want 0", out_valid); end
        show_frame(16'h4321);
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL recapture_valid: got %b want 1", out_valid); end
        tests_run++; if (out !== 16'h4321) begin tests_failed++; $display("FAIL recapture_out: got %h want 4321", out); end
    endtask

`ifdef SEG_SCAN_DECODER_DP_EN
    task automatic test_dp();
        do_reset();
        for (int dg = 3; dg >= 0; dg--) begin
            dp = (dg == 3);
            show(4'b0001 << dg, PAT_TAB[dg], STABLE);
        end
        dp = 1'b0;
        show(4'b0000, 7'b0000000, 1);
        tests_run++; if (out_dp !== 4'b1000) begin tests_failed++; $display("FAIL dp_out: got %b want 1000", out_dp); end
    endtask
`endif

    task automatic test_random();
        int hold;
        do_reset();
        for (int s = 0; s < 400; s++) begin
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 8) an = 4'b0001 << $urandom_range(0, 3);
            else an = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) < 17) seg = PAT_TAB[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
                reset = 1'b0;
                tests_run++; if (out_valid !== m_ov) begin tests_failed++; $display("FAIL rand_valid: seg %0d got %b want %b", s, out_valid, m_ov); end
                tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL rand_out: seg %0d got %h want %h", s, out, m_out); end
                tests_run++; if (err !== m_err) begin tests_failed++; $display("FAIL rand_err: seg %0d got %b want %b", s, err, m_err); end
                tests_run++; if (drop !== m_drop) begin tests_failed++; $display("FAIL rand_drop: seg %0d got %b want %b", s, drop, m_drop); end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_settle();
        test_invalid();
        test_drop();
        test_not_one_hot();
`ifdef SEG_SCAN_DECODER_DP_EN
        test_dp();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (range 1..255).
REQ-002 Parameter SEG_ACTIVE_LOW, default 0: when 1, segment and digit-select inputs are inverted before use.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a, b, c, d, e, f, g  input  1 each  seven-segment lines from the display bus.
REQ-006 an  input  4  digit select, one-hot; bit i selects digit i.
REQ-007 out  output  16  captured frame; digit i in out[4i+3:4i].
REQ-008 out_valid  output  1  out holds an unconsumed frame.
REQ-009 out_ready  input  1  consumer accepts the frame.
REQ-010 err  output  4  sticky per-digit flag: an unrecognised stable pattern was seen on digit i.
REQ-011 drop  output  1  sticky flag: a completed frame was discarded.

Function
REQ-012 Inputs shall be registered once before decoding; all latencies below count from that register.
REQ-013 Decode table {a..g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-014 Per-scan FSM states: IDLE (an not one-hot), SETTLE (counting stable samples), HELD (digit captured; waiting for an or pattern change).
REQ-015 IDLE->SETTLE when an becomes one-hot; counter loads 1.
REQ-016 In SETTLE, an unchanged pattern and an increment the counter; any change restarts the count at 1 for the new value; an not one-hot moves to IDLE.
REQ-017 On the cycle the counter reaches STABLE_CYCLES: a valid pattern writes the nibble into the frame buffer slot for that digit and sets its mask bit; an invalid pattern sets err[i] and leaves the slot and mask unchanged; the FSM moves to HELD.
REQ-018 HELD->SETTLE on any pattern or an change (one-hot); HELD->IDLE if an is not one-hot.
REQ-019 When the mask reaches 4'b1111: if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, out loads the frame and out_valid=1 next cycle; otherwise the frame is discarded and drop sets. The mask clears in either case.
REQ-020 out_valid clears on the cycle after out_valid&out_ready, unless a new frame loads in that same cycle.
REQ-021 out shall remain stable while out_valid=1 and out_ready=0.
REQ-022 Recapturing a digit already in the mask overwrites its slot; this is not an error.
REQ-023 With STABLE_CYCLES=1, capture occurs on the first one-hot sample.

Reset
REQ-024 On reset: out=16'h0000, out_valid=0, err=4'b0000, drop=0, mask=0, counter=0, FSM=IDLE, input register cleared.
REQ-025 Reset asserted mid-settle or mid-frame discards all partial state; no frame is emitted.
REQ-026 err and drop clear only on reset.

Configuration
REQ-027 Macro SEG_SCAN_DECODER_DP_EN: when defined, adds input dp (1) and output out_dp (4); dp is included in the stability comparison and captured alongside the nibble into out_dp[i]; out_dp resets to 0.
REQ-028 When not defined, dp and out_dp do not exist, and behaviour is exactly as above.

Structure
REQ-029 Shared package seg_pkg shall hold the 16-entry segment pattern constants, the FSM state typedef, and the counter width constant (8).
REQ-030 Sub-module seg_pattern_decode (combinational, 7-bit pattern -> 4-bit nibble + valid bit) shall be instantiated once.

Verification
REQ-031 STABLE_CYCLES=4, an=0001 with pattern 1111001 for 4 cycles, then 0010/0110000, 0100/1101101, 1000/1111110 -> out=16'h0213, out_valid=1; err=0.
REQ-032 Pattern toggles on digit 0 after 2 cycles, then holds -> capture occurs 4 cycles after the last change; no earlier capture.
REQ-033 Stable pattern 0000001 on digit 2 -> err=4'b0100; mask bit 2 stays 0; no frame is emitted until a valid digit 2 is captured.
REQ-034 out_ready=0 with two full frames (16'h1234, then 16'h5678) -> out stays 16'h1234 and drop=1; with out_ready=1 on the completion cycle, out=16'h5678 and drop=0.
REQ-035 an=0011 for 10 cycles -> no capture occurs and the counter stays 0; reset pulsed after 3 of 4 digits -> no frame follows until all four digits are recaptured.
REQ-036 With SEG_SCAN_DECODER_DP_EN defined, dp=1 on digit 3 only -> out_dp=4'b1000.
